// File: rtl/rf_sequencer_pkg.sv
// Shared defaults, derived geometry and FSM encoding for the receptive-field sequencer.
package rf_sequencer_pkg;

  localparam int unsigned RF_DATA_WIDTH = 16;
  localparam int unsigned RF_H          = 32;
  localparam int unsigned RF_W          = 32;
  localparam int unsigned RF_F          = 5;
  localparam int unsigned RF_OW         = RF_W - RF_F + 1;
  localparam int unsigned RF_OH         = RF_H - RF_F + 1;
  localparam int unsigned RF_N          = RF_OW / 2;

  // rowNumber/column are exported at this width regardless of image size.
  localparam int unsigned CNT_WIDTH = 6;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ADVANCE,
    FINISH
  } state_t;

endpackage

// File: rtl/rf_pass_counter.sv
// Row / half-row counter walking the output map two passes per row; flags the final pass.
module rf_pass_counter
  import rf_sequencer_pkg::*;
#(
  parameter int unsigned OH = RF_OH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  output logic [CNT_WIDTH-1:0] row,
  output logic [CNT_WIDTH-1:0] column,
  output logic                 last
);

  localparam logic [CNT_WIDTH-1:0] LAST_ROW = CNT_WIDTH'(OH - 1);
  localparam logic [CNT_WIDTH-1:0] COL_HI   = CNT_WIDTH'(1);

  assign last = (column == COL_HI) && (row == LAST_ROW);

  // Advancing past the last pass is a no-op so the final position stays visible.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row    <= '0;
      column <= '0;
    end else if (advance && !last) begin
      if (column == COL_HI) begin
        column <= '0;
        row    <= row + 1'b1;
      end else begin
        column <= COL_HI;
      end
    end
  end

endmodule

// File: rtl/rf_sequencer.sv
// Sequences conv-unit passes over the output map and assembles their results into output_image.
module rf_sequencer
  import rf_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned H          = RF_H,
  parameter int unsigned W          = RF_W,
  parameter int unsigned F          = RF_F
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic                                              conv_done,
  input  logic [0:((W-F+1)/2)*DATA_WIDTH-1]                 conv_result,
  output logic [CNT_WIDTH-1:0]                              rowNumber,
  output logic [CNT_WIDTH-1:0]                              column,
  output logic                                              conv_start,
  output logic                                              busy,
  output logic                                              done,
  output logic [0:(H-F+1)*(W-F+1)*DATA_WIDTH-1]             output_image
);

  localparam int unsigned OW = W - F + 1;
  localparam int unsigned OH = H - F + 1;
  localparam int unsigned N  = OW / 2;

  state_t      state;
  logic        last;
  logic        clear;
  logic        advance;
  int unsigned base;

  assign clear   = (state == IDLE) && start;
  assign advance = (state == ADVANCE);

  rf_pass_counter #(
    .OH(OH)
  ) u_pass_counter (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .advance(advance),
    .row    (rowNumber),
    .column (column),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      conv_start <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= ISSUE;
            conv_start <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (conv_done) state <= ADVANCE;
        end
        ADVANCE: begin
          if (last) begin
            state <= FINISH;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state      <= ISSUE;
            conv_start <= 1'b1;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb base = 32'(rowNumber) * OW + 32'(column) * N;

  always_ff @(posedge clk) begin
    if (reset) begin
      output_image <= '0;
    end else if ((state == WAIT) && conv_done) begin
      for (int unsigned j = 0; j < N; j++) begin
        output_image[(base + j) * DATA_WIDTH +: DATA_WIDTH] <= conv_result[j * DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench for rf_sequencer: single-step vector table plus full-image scoreboard runs.
module tb_rf_sequencer;

  localparam int DW = 16;
  localparam int OW = 28;
  localparam int OH = 28;
  localparam int N  = 14;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  start = 1'b0;
  logic                  conv_done = 1'b0;
  logic [0:N*DW-1]       conv_result;
  logic [5:0]            rowNumber;
  logic [5:0]            column;
  logic                  conv_start;
  logic                  busy;
  logic                  done;
  logic [0:OH*OW*DW-1]   output_image;

  int seed = 7;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int row;
    int col;
  } pass_t;
  pass_t exp_q[$];
  int    pass_cnt = 0;
  bit    mon_en = 1'b0;

  typedef struct {
    logic rst;
    logic st;
    logic cd;
    logic e_cs;
    logic e_busy;
    logic e_done;
    int   e_row;
    int   e_col;
    int   e_w0;
    int   e_w14;
    int   e_w28;
  } vec_t;
  vec_t vt[13];

  rf_sequencer #(
    .DATA_WIDTH(16),
    .H(32),
    .W(32),
    .F(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .conv_done   (conv_done),
    .conv_result (conv_result),
    .rowNumber   (rowNumber),
    .column      (column),
    .conv_start  (conv_start),
    .busy        (busy),
    .done        (done),
    .output_image(output_image)
  );

  always #5 clk = ~clk;

  // Conv-unit model: output column c of row r yields seed + r*100 + c.
  always_comb begin
    conv_result = '0;
    for (int j = 0; j < N; j++)
      conv_result[j*DW +: DW] = 16'(seed + int'(rowNumber) * 100 + int'(column) * N + j);
  end

  function automatic int exp_pix(input int s, input int idx);
    return int'(16'(s + (idx / OW) * 100 + (idx % OW)));
  endfunction

  function automatic int word(input int idx);
    return int'(output_image[idx*DW +: DW]);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_image(input string name, input bit zero, input int s);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < OH*OW; i++) begin
      if (word(i) != (zero ? 0 : exp_pix(s, i))) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL %s: %0d bad words, first at %0d got %0d expected %0d", name, bad, first,
               word(first), zero ? 0 : exp_pix(s, first));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && conv_start) begin
      pass_t e;
      pass_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL pass_order: unexpected conv_start at row %0d col %0d", rowNumber, column);
      end else begin
        e = exp_q.pop_front();
        if (int'(rowNumber) != e.row || int'(column) != e.col) begin
          miscompares++;
          $display("FAIL pass_order: got row %0d col %0d expected row %0d col %0d",
                   rowNumber, column, e.row, e.col);
        end
      end
    end
  end

  // Runs one image from the current negedge; conv_done follows each conv_start after a delay.
  task automatic run_image(input int slow_delay, input bit hold, input int poke_row,
                           input int abort_row, input int old_seed, output bit aborted);
    int countdown = -1;
    bit poked = 1'b0;
    bit busy_chk = 1'b0;
    int cyc = 0;
    aborted = 1'b0;
    exp_q.delete();
    pass_cnt = 0;
    for (int r = 0; r < OH; r++)
      for (int c = 0; c < 2; c++) exp_q.push_back('{r, c});
    start = 1'b1;
    conv_done = hold;
    mon_en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    check("done_after_start", int'(done), 0);
    if (old_seed >= 0) check("image_kept_on_start", word(OH*OW-1), exp_pix(old_seed, OH*OW-1));
    while (!done) begin
      conv_done = hold;
      start = 1'b0;
      if (busy_chk) begin
        check("busy_after_midrun_start", int'(busy), 1);
        busy_chk = 1'b0;
      end
      if (conv_start) begin
        countdown = (rowNumber == 3 && column == 1) ? slow_delay : 1;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          conv_done = 1'b1;
          if (int'(rowNumber) == abort_row) reset = 1'b1;
        end
      end
      if (!poked && int'(rowNumber) == poke_row) begin
        start = 1'b1;
        poked = 1'b1;
        busy_chk = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (reset) begin
        reset = 1'b0;
        conv_done = 1'b0;
        mon_en = 1'b0;
        aborted = 1'b1;
        check("abort_conv_start", int'(conv_start), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_row", int'(rowNumber), 0);
        check("abort_col", int'(column), 0);
        check_image("abort_image_zero", 1'b1, 0);
        return;
      end
      if (cyc > 2000) begin
        check("run_timeout", cyc, 0);
        break;
      end
    end
    start = 1'b0;
    check("pass_count", pass_cnt, 2*OH);
    check("passes_left", exp_q.size(), 0);
    check("final_busy", int'(busy), 0);
    check("final_row", int'(rowNumber), OH-1);
    check("final_col", int'(column), 1);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("done_held", int'(done), 1);
    check("row_held", int'(rowNumber), OH-1);
    check("col_held", int'(column), 1);
  endtask

  initial begin
    bit ab;
    //        rst st cd  cs bsy dn row col  w0  w14  w28
    vt[0]  = '{1, 0, 0,  0, 0,  0, 0,  0,   0,  0,   0};
    vt[1]  = '{0, 1, 0,  1, 1,  0, 0,  0,   0,  0,   0};
    vt[2]  = '{0, 0, 1,  0, 1,  0, 0,  0,   0,  0,   0};
    vt[3]  = '{0, 1, 0,  0, 1,  0, 0,  0,   0,  0,   0};
    vt[4]  = '{0, 0, 1,  0, 1,  0, 0,  0,   7,  0,   0};
    vt[5]  = '{0, 0, 1,  1, 1,  0, 0,  1,   7,  0,   0};
    vt[6]  = '{0, 0, 1,  0, 1,  0, 0,  1,   7,  0,   0};
    vt[7]  = '{0, 0, 0,  0, 1,  0, 0,  1,   7,  0,   0};
    vt[8]  = '{0, 0, 1,  0, 1,  0, 0,  1,   7,  21,  0};
    vt[9]  = '{0, 0, 0,  1, 1,  0, 1,  0,   7,  21,  0};
    vt[10] = '{0, 0, 0,  0, 1,  0, 1,  0,   7,  21,  0};
    vt[11] = '{1, 1, 1,  0, 0,  0, 0,  0,   0,  0,   0};
    vt[12] = '{0, 0, 0,  0, 0,  0, 0,  0,   0,  0,   0};

    seed = 7;
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      reset = vt[i].rst;
      start = vt[i].st;
      conv_done = vt[i].cd;
      @(negedge clk);
      vectors++;
      if (conv_start !== vt[i].e_cs || busy !== vt[i].e_busy || done !== vt[i].e_done ||
          int'(rowNumber) != vt[i].e_row || int'(column) != vt[i].e_col ||
          word(0) != vt[i].e_w0 || word(14) != vt[i].e_w14 || word(28) != vt[i].e_w28) begin
        miscompares++;
        $display("FAIL table[%0d]: got cs=%b busy=%b done=%b row=%0d col=%0d w0=%0d w14=%0d w28=%0d expected cs=%b busy=%b done=%b row=%0d col=%0d w0=%0d w14=%0d w28=%0d",
                 i, conv_start, busy, done, rowNumber, column, word(0), word(14), word(28),
                 vt[i].e_cs, vt[i].e_busy, vt[i].e_done, vt[i].e_row, vt[i].e_col,
                 vt[i].e_w0, vt[i].e_w14, vt[i].e_w28);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    conv_done = 1'b0;

    seed = 0;
    run_image(1, 1'b0, -1, -1, -1, ab);
    check_image("image_basic", 1'b0, 0);

    seed = 1000;
    run_image(10, 1'b0, 5, -1, 0, ab);
    check_image("image_slow_poke", 1'b0, 1000);
    for (int k = 98; k <= 111; k++) check("slow_pass_word", word(k), exp_pix(1000, k));

    seed = 2000;
    run_image(1, 1'b0, -1, 12, -1, ab);
    check("abort_taken", int'(ab), 1);

    seed = 3000;
    run_image(1, 1'b0, -1, -1, -1, ab);
    check_image("image_after_abort", 1'b0, 3000);

    seed = 4000;
    run_image(1, 1'b1, -1, -1, 3000, ab);
    check_image("image_hold_done", 1'b0, 4000);

    conv_done = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_cleared_by_start", int'(done), 0);
    check("busy_set_by_start", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
